// File: rtl/main_fsm.sv
// Multicycle ARM controller main FSM: sequences fetch/decode/execute and decodes datapath controls.
// Optional MAIN_FSM_MEMWAIT_EN: FETCH, MEMREAD and MEMWRITE stall until MemReady.
module main_fsm #(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch
);

    localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXECR    = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_EXECI    = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_UNKNOWN  = STATE_W'(10);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               mem_go;
    logic               unused_funct;

    assign unused_funct = ^Funct[4:1];

`ifdef MAIN_FSM_MEMWAIT_EN
    assign mem_go = MemReady;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = MemReady;
    assign mem_go           = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_go ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_go ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_go ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_UNKNOWN:  state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Illegal encodings fall through to the all-zero defaults, same as UNKNOWN.
    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'd0;
        ALUSrcB   = 2'd0;
        ResultSrc = 2'd0;
        ALUOp     = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite   = mem_go;
                NextPC    = mem_go;
                ALUSrcA   = 2'd1;
                ALUSrcB   = 2'd2;
                ResultSrc = 2'd2;
            end
            S_DECODE: begin
                ALUSrcA   = 2'd1;
                ALUSrcB   = 2'd2;
                ResultSrc = 2'd2;
            end
            S_MEMADR:   ALUSrcB = 2'd1;
            S_MEMREAD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'd1;
                RegW      = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            S_EXECR:    ALUOp = 1'b1;
            S_EXECI: begin
                ALUSrcB = 2'd1;
                ALUOp   = 1'b1;
            end
            S_ALUWB:    RegW = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = 2'd1;
                ResultSrc = 2'd2;
                Branch    = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: random instructions, expected per-cycle control vectors from a phase-level model.
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       IRWrite, AdrSrc, ALUOp, NextPC, RegW, MemW, Branch;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;

    int errors = 0;
    int checks = 0;

`ifdef MAIN_FSM_MEMWAIT_EN
    localparam bit MEMWAIT = 1'b1;
`else
    localparam bit MEMWAIT = 1'b0;
`endif

    typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                  P_EXECR, P_EXECI, P_ALUWB, P_BRANCH, P_UNKNOWN} phase_e;

    logic [12:0] exp_q[$];
    string       name_q[$];
    logic [12:0] act;

    main_fsm #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUOp(ALUOp), .NextPC(NextPC), .RegW(RegW),
        .MemW(MemW), .Branch(Branch)
    );

    always #5 clk = ~clk;

    assign act = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch};

    // Control vector: {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch}
    function automatic logic [12:0] mk(input logic irw, input logic adr, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] rs, input logic aop,
                                       input logic npc, input logic rw, input logic mw, input logic br);
        return {irw, adr, sa, sb, rs, aop, npc, rw, mw, br};
    endfunction

    function automatic logic [12:0] phase_vec(input phase_e p, input logic rdy);
        case (p)
            P_FETCH:    return mk(rdy, 0, 2'd1, 2'd2, 2'd2, 0, rdy, 0, 0, 0);
            P_DECODE:   return mk(0, 0, 2'd1, 2'd2, 2'd2, 0, 0, 0, 0, 0);
            P_MEMADR:   return mk(0, 0, 2'd0, 2'd1, 2'd0, 0, 0, 0, 0, 0);
            P_MEMREAD:  return mk(0, 1, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0);
            P_MEMWB:    return mk(0, 0, 2'd0, 2'd0, 2'd1, 0, 0, 1, 0, 0);
            P_MEMWRITE: return mk(0, 1, 2'd0, 2'd0, 2'd0, 0, 0, 0, 1, 0);
            P_EXECR:    return mk(0, 0, 2'd0, 2'd0, 2'd0, 1, 0, 0, 0, 0);
            P_EXECI:    return mk(0, 0, 2'd0, 2'd1, 2'd0, 1, 0, 0, 0, 0);
            P_ALUWB:    return mk(0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 1, 0, 0);
            P_BRANCH:   return mk(0, 0, 2'd0, 2'd1, 2'd2, 0, 0, 0, 0, 1);
            default:    return 13'd0;
        endcase
    endfunction

    // Monitor: one comparison per cycle while the scoreboard holds expectations.
    initial begin
        logic [12:0] e;
        string       n;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got %013b expected %013b at %0t", n, act, e, $time);
                end
            end
        end
    end

    // Reference model: instruction class -> phase list; hold phases stretch by random MemReady waits.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input int max_wait);
        phase_e ph[$];
        logic   drv_q[$];
        int     w;
        logic   rdy;
        bit     holdable;
        string  cls;
        ph = '{P_FETCH, P_DECODE};
        case (op)
            2'b00: begin
                ph.push_back(fn[5] ? P_EXECI : P_EXECR);
                ph.push_back(P_ALUWB);
                cls = fn[5] ? "DPimm" : "DPreg";
            end
            2'b01: begin
                ph.push_back(P_MEMADR);
                if (fn[0]) begin
                    ph.push_back(P_MEMREAD);
                    ph.push_back(P_MEMWB);
                    cls = "LDR";
                end else begin
                    ph.push_back(P_MEMWRITE);
                    cls = "STR";
                end
            end
            2'b10: begin
                ph.push_back(P_BRANCH);
                cls = "B";
            end
            default: begin
                ph.push_back(P_UNKNOWN);
                cls = "UND";
            end
        endcase
        foreach (ph[i]) begin
            holdable = (ph[i] == P_FETCH) || (ph[i] == P_MEMREAD) || (ph[i] == P_MEMWRITE);
            w = (MEMWAIT && holdable) ? $urandom_range(0, max_wait) : 0;
            for (int k = 0; k <= w; k++) begin
                if (MEMWAIT && holdable) rdy = (k == w);
                else rdy = 1'($urandom);
                exp_q.push_back(phase_vec(ph[i], MEMWAIT ? rdy : 1'b1));
                name_q.push_back($sformatf("%s_%s_c%0d", cls, ph[i].name(), k));
                drv_q.push_back(rdy);
            end
        end
        $display("instr %s op=%02b funct=%06b cycles=%0d", cls, op, fn, drv_q.size());
        Op    = op;
        Funct = fn;
        foreach (drv_q[i]) begin
            MemReady = drv_q[i];
            @(negedge clk);
        end
    endtask

    task automatic direct_check(input string n, input logic [12:0] e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got %013b expected %013b at %0t", n, act, e, $time);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        Op       = 2'b00;
        Funct    = 6'd0;
        MemReady = 1'b1;
        @(negedge clk);
        #1;
        direct_check("reset_values", phase_vec(P_FETCH, 1'b1));
        @(negedge clk);
        reset = 1'b0;

        run_instr(2'b00, 6'b001000, 0);
        run_instr(2'b01, 6'b011001, 0);
        run_instr(2'b01, 6'b011000, 0);
        run_instr(2'b10, 6'b000000, 0);
        run_instr(2'b11, 6'b000000, 0);
        run_instr(2'b00, 6'b101000, 0);
        run_instr(2'b00, 6'b001000, 3);
        run_instr(2'b01, 6'b011000, 2);

        // Async reset mid-MEMREAD must return to FETCH without waiting for a clock edge.
        Op       = 2'b01;
        Funct    = 6'b011001;
        MemReady = 1'b1;
        exp_q.push_back(phase_vec(P_FETCH, 1'b1));  name_q.push_back("rst_FETCH");
        exp_q.push_back(phase_vec(P_DECODE, 1'b1)); name_q.push_back("rst_DECODE");
        exp_q.push_back(phase_vec(P_MEMADR, 1'b1)); name_q.push_back("rst_MEMADR");
        exp_q.push_back(phase_vec(P_MEMREAD, 1'b1)); name_q.push_back("rst_MEMREAD");
        repeat (3) @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        direct_check("async_reset_midread", phase_vec(P_FETCH, 1'b1));
        @(negedge clk);
        direct_check("reset_held", phase_vec(P_FETCH, 1'b1));
        reset = 1'b0;

        for (int i = 0; i < 200; i++) begin
            run_instr(2'($urandom), 6'($urandom), 3);
        end

        @(negedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
